// File: rtl/uc_bcast_sched.sv
// Broadcast scheduler: pops one mstack literal at a time and delivers it once to every enabled engine UCQ.
// Optional statistics counters are built only when UC_BCAST_STATS_EN is defined.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 16
`endif

module uc_bcast_sched #(
    parameter int NUM_ENGINE = `NUM_ENGINE,
    parameter int LIT_W      = `LIT_IDX_MAX*2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mstack_empty_i,
    input  logic [LIT_W-1:0]      mstack_lit_i,
    output logic                  mstack_pop_o,
    input  logic [NUM_ENGINE-1:0] eng_en_i,
    input  logic [NUM_ENGINE-1:0] ucq_full_i,
    output logic [NUM_ENGINE-1:0] ucq_push_o,
    output logic [LIT_W-1:0]      ucq_lit_o,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      stat_lits_o,
    output logic [CNT_W-1:0]      stat_stall_o
);
    // state | meaning
    // IDLE  | pending_q == 0, the next mstack literal may load
    // SEND  | pending_q != 0, lit_q still owed to the engines flagged in pending_q
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                state;
    logic [NUM_ENGINE-1:0] pending_q, pending_d;
    logic [NUM_ENGINE-1:0] push, rem;
    logic [LIT_W-1:0]      lit_q, lit_d;
    logic                  load;

    assign state = (pending_q != '0) ? ST_SEND : ST_IDLE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            lit_q     <= '0;
        end else begin
            pending_q <= pending_d;
            lit_q     <= lit_d;
        end
    end

    // The last delivery and the next load share a cycle, giving one literal per cycle.
    always_comb begin
        push      = '0;
        rem       = '0;
        load      = 1'b0;
        pending_d = pending_q;
        lit_d     = lit_q;
        if (!rst_i) begin
            push = pending_q & eng_en_i & ~ucq_full_i;
        end
        rem  = pending_q & eng_en_i & ~push;
        load = (rem == '0) && !mstack_empty_i && !flush_i && !rst_i;
        if (flush_i) begin
            pending_d = '0;
        end else if (load) begin
            pending_d = eng_en_i;
            lit_d     = mstack_lit_i;
        end else begin
            pending_d = rem;
        end
    end

    assign mstack_pop_o = load;
    assign ucq_push_o   = push;
    assign ucq_lit_o    = lit_q;
    assign busy_o       = (state == ST_SEND);

`ifdef UC_BCAST_STATS_EN
    logic [CNT_W-1:0] lits_q, stall_q;
    logic             last_dlv, stall;

    assign last_dlv = (state == ST_SEND) && (rem == '0) && !flush_i;
    assign stall    = (state == ST_SEND) && ((pending_q & ucq_full_i) != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lits_q  <= '0;
            stall_q <= '0;
        end else begin
            if (last_dlv) lits_q  <= lits_q + CNT_W'(1);
            if (stall)    stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stat_lits_o  = lits_q;
    assign stat_stall_o = stall_q;
`else
    assign stat_lits_o  = '0;
    assign stat_stall_o = '0;
`endif

endmodule
